// File: rtl/stream_packet_sink.sv
// AXI-Stream packet terminator: buffers one packet (up to t_last) and holds it
// for a word-addressed reader until pkt_ack releases it.
module stream_packet_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = $clog2(DEPTH + 1),
    localparam int CW = $clog2(DEPTH * STRB_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ID_WIDTH-1:0]   t_id,
    input  logic [DEST_WIDTH-1:0] t_dest,
    input  logic [DATA_WIDTH-1:0] t_data,
    input  logic [STRB_WIDTH-1:0] t_strb,
    input  logic [STRB_WIDTH-1:0] t_keep,
    input  logic                  t_last,
    input  logic [USER_WIDTH-1:0] t_user,
    input  logic                  t_valid,
    output logic                  t_ready,
    output logic                  pkt_valid,
    output logic [BW-1:0]         pkt_beats,
    output logic [CW-1:0]         pkt_bytes,
    output logic                  pkt_trunc,
    output logic [ID_WIDTH-1:0]   pkt_id,
    output logic [DEST_WIDTH-1:0] pkt_dest,
    output logic [USER_WIDTH-1:0] pkt_user,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [STRB_WIDTH-1:0] rd_keep,
    output logic [STRB_WIDTH-1:0] rd_strb,
    input  logic                  pkt_ack
);

    // state | meaning
    // RECV  | accepting beats of the current packet
    // HOLD  | complete packet held for the reader, waiting for pkt_ack
    typedef enum logic {RECV = 1'b0, HOLD = 1'b1} state_t;

    state_t state, state_next;
    logic   ready_next, valid_next;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [STRB_WIDTH-1:0] mem_keep [DEPTH];
    logic [STRB_WIDTH-1:0] mem_strb [DEPTH];

    logic          started;
    logic          accept, store, release_pkt;
    logic [CW-1:0] keep_count;

    assign accept      = t_valid && t_ready;
    assign store       = accept && (|t_keep) && (pkt_beats < BW'(DEPTH));
    assign release_pkt = (state == HOLD) && pkt_ack;

    always_comb begin
        keep_count = '0;
        for (int i = 0; i < STRB_WIDTH; i++)
            keep_count = keep_count + CW'(t_keep[i]);
    end

    always_comb begin
        state_next = state;
        case (state)
            RECV: if (accept && t_last) state_next = HOLD;
            HOLD: if (pkt_ack) state_next = RECV;
            default: state_next = RECV;
        endcase
        ready_next = (state_next == RECV);
        valid_next = (state_next == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= RECV;
            t_ready   <= 1'b0;
            pkt_valid <= 1'b0;
        end else begin
            state     <= state_next;
            t_ready   <= ready_next;
            pkt_valid <= valid_next;
        end
    end

    // started distinguishes the first accepted beat even when it is a null beat
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pkt_beats <= '0;
            pkt_bytes <= '0;
            pkt_trunc <= 1'b0;
            pkt_id    <= '0;
            pkt_dest  <= '0;
            pkt_user  <= '0;
            started   <= 1'b0;
        end else if (release_pkt) begin
            pkt_beats <= '0;
            pkt_bytes <= '0;
            pkt_trunc <= 1'b0;
            started   <= 1'b0;
        end else if (accept) begin
            started <= 1'b1;
            if (!started) begin
                pkt_id   <= t_id;
                pkt_dest <= t_dest;
            end
            if (store) begin
                pkt_beats <= pkt_beats + BW'(1);
                pkt_bytes <= pkt_bytes + keep_count;
            end else if (pkt_beats == BW'(DEPTH)) begin
                pkt_trunc <= 1'b1;
            end
            if (t_last)
                pkt_user <= t_user;
        end
    end

    // Buffer contents survive reset; only the read registers are cleared.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_data[pkt_beats[AW-1:0]] <= t_data;
            mem_keep[pkt_beats[AW-1:0]] <= t_keep;
            mem_strb[pkt_beats[AW-1:0]] <= t_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data <= '0;
            rd_keep <= '0;
            rd_strb <= '0;
        end else begin
            rd_data <= mem_data[rd_addr];
            rd_keep <= mem_keep[rd_addr];
            rd_strb <= mem_strb[rd_addr];
        end
    end

endmodule

// File: tb/tb_stream_packet_sink.sv
// Directed bench for stream_packet_sink: capture, read-back, truncation,
// null beats, hold/ack handshake and mid-packet reset.
module tb_stream_packet_sink;

    logic        clk = 1'b0;
    logic        rstn;
    logic [0:0]  t_id, t_dest, t_user;
    logic [31:0] t_data;
    logic [3:0]  t_strb, t_keep;
    logic        t_last, t_valid, t_ready;
    logic        pkt_valid, pkt_trunc;
    logic [4:0]  pkt_beats;
    logic [6:0]  pkt_bytes;
    logic [0:0]  pkt_id, pkt_dest, pkt_user;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  rd_keep, rd_strb;
    logic        pkt_ack;

    int checks = 0;
    int errors = 0;

    stream_packet_sink dut (
        .clk(clk), .rstn(rstn), .t_id(t_id), .t_dest(t_dest), .t_data(t_data),
        .t_strb(t_strb), .t_keep(t_keep), .t_last(t_last), .t_user(t_user),
        .t_valid(t_valid), .t_ready(t_ready), .pkt_valid(pkt_valid),
        .pkt_beats(pkt_beats), .pkt_bytes(pkt_bytes), .pkt_trunc(pkt_trunc),
        .pkt_id(pkt_id), .pkt_dest(pkt_dest), .pkt_user(pkt_user),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_keep(rd_keep),
        .rd_strb(rd_strb), .pkt_ack(pkt_ack)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [3:0] keep,
                             input logic last, input logic id, input logic dest,
                             input logic user);
        t_data  = data;
        t_keep  = keep;
        t_strb  = keep ^ 4'hA;
        t_last  = last;
        t_id    = id;
        t_dest  = dest;
        t_user  = user;
        t_valid = 1'b1;
        cycle();
        t_valid = 1'b0;
        t_last  = 1'b0;
    endtask

    task automatic do_ack();
        pkt_ack = 1'b1;
        cycle();
        pkt_ack = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; t_valid = 1'b0; t_last = 1'b0; t_data = '0; t_keep = '0;
        t_strb = '0; t_id = '0; t_dest = '0; t_user = '0; rd_addr = '0; pkt_ack = 1'b0;
        cycle(); cycle();
        checks++; if (t_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", t_ready); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", pkt_valid); end
        checks++; if (pkt_beats !== 5'd0 || pkt_bytes !== 7'd0 || pkt_trunc !== 1'b0)
            begin errors++; $display("FAIL reset_counts got %0d/%0d/%0b exp 0/0/0", pkt_beats, pkt_bytes, pkt_trunc); end
        checks++; if (rd_data !== 32'd0 || rd_keep !== 4'd0 || rd_strb !== 4'd0)
            begin errors++; $display("FAIL reset_rd got %h/%h/%h exp 0", rd_data, rd_keep, rd_strb); end
        rstn = 1'b1;
        cycle();
        checks++; if (t_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b exp 1", t_ready); end
    endtask

    task automatic test_basic_packet();
        logic [31:0] exp_data [3];
        logic [3:0]  exp_keep [3];
        exp_data[0] = 32'hA0A0_0001; exp_keep[0] = 4'hF;
        exp_data[1] = 32'hA0A0_0002; exp_keep[1] = 4'hF;
        exp_data[2] = 32'hA0A0_0003; exp_keep[2] = 4'h3;
        send_beat(exp_data[0], exp_keep[0], 1'b0, 1'b1, 1'b0, 1'b0);
        send_beat(exp_data[1], exp_keep[1], 1'b0, 1'b0, 1'b1, 1'b0);
        send_beat(exp_data[2], exp_keep[2], 1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (pkt_valid !== 1'b1 || t_ready !== 1'b0)
            begin errors++; $display("FAIL basic_hold valid=%0b ready=%0b exp 1/0", pkt_valid, t_ready); end
        checks++; if (pkt_beats !== 5'd3 || pkt_bytes !== 7'd10 || pkt_trunc !== 1'b0)
            begin errors++; $display("FAIL basic_counts got %0d/%0d/%0b exp 3/10/0", pkt_beats, pkt_bytes, pkt_trunc); end
        checks++; if (pkt_id !== 1'b1 || pkt_dest !== 1'b0 || pkt_user !== 1'b1)
            begin errors++; $display("FAIL basic_fields got %0b/%0b/%0b exp 1/0/1", pkt_id, pkt_dest, pkt_user); end
        for (int i = 0; i < 3; i++) begin
            rd_addr = 4'(i);
            cycle();
            checks++;
            if (rd_data !== exp_data[i] || rd_keep !== exp_keep[i] || rd_strb !== (exp_keep[i] ^ 4'hA)) begin
                errors++;
                $display("FAIL basic_read[%0d] got %h/%h/%h exp %h/%h/%h", i, rd_data, rd_keep, rd_strb,
                         exp_data[i], exp_keep[i], exp_keep[i] ^ 4'hA);
            end
        end
    endtask

    task automatic test_hold_ack();
        t_data = 32'hDEAD_BEEF; t_keep = 4'hF; t_strb = 4'hF; t_last = 1'b1; t_valid = 1'b1;
        rd_addr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (t_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %0b exp 0", i, t_ready); end
        end
        checks++; if (pkt_beats !== 5'd3 || pkt_bytes !== 7'd10 || rd_data !== 32'hA0A0_0001)
            begin errors++; $display("FAIL hold_no_capture got %0d/%0d/%h exp 3/10/a0a00001", pkt_beats, pkt_bytes, rd_data); end
        t_valid = 1'b0; t_last = 1'b0;
        do_ack();
        checks++; if (t_ready !== 1'b1 || pkt_valid !== 1'b0)
            begin errors++; $display("FAIL ack_state ready=%0b valid=%0b exp 1/0", t_ready, pkt_valid); end
        checks++; if (pkt_beats !== 5'd0 || pkt_bytes !== 7'd0 || pkt_trunc !== 1'b0)
            begin errors++; $display("FAIL ack_clear got %0d/%0d/%0b exp 0/0/0", pkt_beats, pkt_bytes, pkt_trunc); end
    endtask

    task automatic test_truncation();
        int not_ready = 0;
        for (int i = 1; i <= 20; i++) begin
            if (t_ready !== 1'b1) not_ready++;
            send_beat(32'h1000_0000 + 32'(i), 4'hF, (i == 20), 1'b0, 1'b0, 1'b1);
        end
        checks++; if (not_ready != 0) begin errors++; $display("FAIL trunc_ready_drops got %0d exp 0", not_ready); end
        checks++; if (pkt_valid !== 1'b1 || pkt_beats !== 5'd16 || pkt_bytes !== 7'd64 || pkt_trunc !== 1'b1)
            begin errors++; $display("FAIL trunc_counts got %0b/%0d/%0d/%0b exp 1/16/64/1", pkt_valid, pkt_beats, pkt_bytes, pkt_trunc); end
        rd_addr = 4'd15;
        cycle();
        checks++; if (rd_data !== 32'h1000_0010) begin errors++; $display("FAIL trunc_last_entry got %h exp 10000010", rd_data); end
        do_ack();
        checks++; if (pkt_trunc !== 1'b0) begin errors++; $display("FAIL trunc_cleared got %0b exp 0", pkt_trunc); end
    endtask

    task automatic test_null_beat();
        send_beat(32'hB000_0001, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
        pkt_ack = 1'b1;
        send_beat(32'hB000_0002, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        pkt_ack = 1'b0;
        send_beat(32'hB000_0003, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_beat(32'hB000_0004, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (pkt_valid !== 1'b1 || pkt_beats !== 5'd3 || pkt_bytes !== 7'd7)
            begin errors++; $display("FAIL null_counts got %0b/%0d/%0d exp 1/3/7", pkt_valid, pkt_beats, pkt_bytes); end
        checks++; if (pkt_id !== 1'b1 || pkt_dest !== 1'b1 || pkt_user !== 1'b1)
            begin errors++; $display("FAIL null_fields got %0b/%0b/%0b exp 1/1/1", pkt_id, pkt_dest, pkt_user); end
        rd_addr = 4'd1;
        cycle();
        checks++; if (rd_data !== 32'hB000_0003 || rd_keep !== 4'h1)
            begin errors++; $display("FAIL null_read got %h/%h exp b0000003/1", rd_data, rd_keep); end
        do_ack();
        send_beat(32'hC000_0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_beats !== 5'd0 || pkt_bytes !== 7'd0 || pkt_id !== 1'b1)
            begin errors++; $display("FAIL null_only got %0b/%0d/%0d/%0b exp 1/0/0/1", pkt_valid, pkt_beats, pkt_bytes, pkt_id); end
        do_ack();
    endtask

    task automatic test_reset_mid_packet();
        send_beat(32'hD000_0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        send_beat(32'hD000_0002, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (pkt_beats !== 5'd2) begin errors++; $display("FAIL midrst_pre got %0d exp 2", pkt_beats); end
        rstn = 1'b0;
        cycle();
        checks++; if (t_ready !== 1'b0 || pkt_valid !== 1'b0 || pkt_beats !== 5'd0)
            begin errors++; $display("FAIL midrst_during got %0b/%0b/%0d exp 0/0/0", t_ready, pkt_valid, pkt_beats); end
        rstn = 1'b1;
        cycle();
        send_beat(32'hE000_0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_beats !== 5'd1 || pkt_bytes !== 7'd4 || pkt_trunc !== 1'b0)
            begin errors++; $display("FAIL midrst_fresh got %0b/%0d/%0d/%0b exp 1/1/4/0", pkt_valid, pkt_beats, pkt_bytes, pkt_trunc); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_hold_ack();
        test_truncation();
        test_null_beat();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
